// File: rtl/ccm_ctr_rx_unpack.sv
// CCM CTR receive unpacker: fetches S0/S1.. keystream blocks, decrypts payload bytes
// through a MIC_LEN-deep holdback line and hands the decrypted MIC tail to the MAC check.
module ccm_ctr_rx_unpack #(
  parameter int WIDTH       = 8,
  parameter int WIDTH_BLOCK = 128,
  parameter int WIDTH_COUNT = 20,
  parameter int MIC_LEN     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         input_data,
  input  logic                     input_en,
  input  logic                     input_last,
  output logic                     out_ready,
  output logic                     ks_req,
  output logic [WIDTH_COUNT-1:0]   ks_count,
  input  logic [WIDTH_BLOCK-1:0]   ks_data,
  input  logic                     ks_en,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_en,
  output logic                     out_last,
  output logic [MIC_LEN*WIDTH-1:0] mic_data,
  output logic                     mic_en,
  output logic                     err_short
);

  localparam int NB     = WIDTH_BLOCK / WIDTH;
  localparam int IDX_W  = $clog2(NB);
  localparam int FILL_W = $clog2(MIC_LEN + 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(MIC_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic [2:0] {S_REQ0, S_REQ1, S_RUN, S_REQN, S_DONE} state_t;

  state_t                   r_state;
  logic [WIDTH_BLOCK-1:0]   r_s0;
  logic [WIDTH_BLOCK-1:0]   r_si;
  logic [WIDTH_COUNT-1:0]   r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [FILL_W-1:0]        r_fill;
  logic [WIDTH-1:0]         r_raw [MIC_LEN];
  logic [WIDTH-1:0]         r_dec [MIC_LEN];
  logic                     r_ks_req;
  logic                     r_out_ready;
  logic [WIDTH-1:0]         r_out_data;
  logic                     r_out_en;
  logic                     r_out_last;
  logic [MIC_LEN*WIDTH-1:0] r_mic_data;
  logic                     r_mic_en;
  logic                     r_err_short;

  logic                     w_accept;
  logic                     w_ks_hs;
  logic                     w_full;
  logic [FILL_W-1:0]        w_fill_nx;
  logic [WIDTH-1:0]         w_si_byte;
  logic [WIDTH-1:0]         w_dec;
  logic [WIDTH-1:0]         w_raw_nx [MIC_LEN];
  logic [WIDTH-1:0]         w_dec_nx [MIC_LEN];
  logic [MIC_LEN*WIDTH-1:0] w_mic;

  assign w_accept  = input_en & r_out_ready;
  assign w_ks_hs   = r_ks_req & ks_en;
  assign w_full    = (r_fill == FULL);
  assign w_fill_nx = w_full ? r_fill : r_fill + 1'b1;
  assign w_dec     = input_data ^ w_si_byte;

  // Byte 0 of a keystream block sits in the MSBs.
  always_comb begin
    w_si_byte = '0;
    for (int j = 0; j < NB; j++)
      if (r_idx == IDX_W'(j)) w_si_byte = r_si[WIDTH_BLOCK-1-WIDTH*j -: WIDTH];
  end

  // Holdback line shifts toward index 0; index 0 is the oldest entry once full.
  always_comb begin
    for (int k = 0; k < MIC_LEN - 1; k++) begin
      w_raw_nx[k] = r_raw[k+1];
      w_dec_nx[k] = r_dec[k+1];
    end
    w_raw_nx[MIC_LEN-1] = input_data;
    w_dec_nx[MIC_LEN-1] = w_dec;
    w_mic = '0;
    for (int k = 0; k < MIC_LEN; k++)
      w_mic[MIC_LEN*WIDTH-1-WIDTH*k -: WIDTH] =
        w_raw_nx[k] ^ r_s0[WIDTH_BLOCK-1-WIDTH*k -: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_REQ0;
      r_s0        <= '0;
      r_si        <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_fill      <= '0;
      for (int k = 0; k < MIC_LEN; k++) begin
        r_raw[k] <= '0;
        r_dec[k] <= '0;
      end
      r_ks_req    <= 1'b0;
      r_out_ready <= 1'b0;
      r_out_data  <= '0;
      r_out_en    <= 1'b0;
      r_out_last  <= 1'b0;
      r_mic_data  <= '0;
      r_mic_en    <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_out_en    <= 1'b0;
      r_out_last  <= 1'b0;
      r_mic_en    <= 1'b0;
      r_err_short <= 1'b0;
      case (r_state)
        // ks_req drops for one cycle after each handshake so ks_count never moves under a live request
        S_REQ0: begin
          r_ks_req <= ~w_ks_hs;
          if (w_ks_hs) begin
            r_s0    <= ks_data;
            r_cnt   <= WIDTH_COUNT'(1);
            r_state <= S_REQ1;
          end
        end
        S_REQ1, S_REQN: begin
          r_ks_req <= ~w_ks_hs;
          if (w_ks_hs) begin
            r_si        <= ks_data;
            r_idx       <= '0;
            r_out_ready <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_raw  <= w_raw_nx;
            r_dec  <= w_dec_nx;
            r_fill <= w_fill_nx;
            r_idx  <= r_idx + 1'b1;
            if (w_full) begin
              r_out_en   <= 1'b1;
              r_out_data <= r_dec[0];
              r_out_last <= input_last;
            end
            if (input_last) begin
              r_out_ready <= 1'b0;
              r_state     <= S_DONE;
              if (w_fill_nx == FULL) begin
                r_mic_en   <= 1'b1;
                r_mic_data <= w_mic;
              end else begin
                r_err_short <= 1'b1;
              end
            end else if (r_idx == LAST_IDX) begin
              r_out_ready <= 1'b0;
              r_cnt       <= r_cnt + 1'b1;
              r_ks_req    <= 1'b1;
              r_state     <= S_REQN;
            end
          end
        end
        S_DONE: begin
          r_cnt    <= '0;
          r_fill   <= '0;
          r_ks_req <= 1'b1;
          r_state  <= S_REQ0;
        end
        default: r_state <= S_REQ0;
      endcase
    end
  end

  assign out_ready = r_out_ready;
  assign ks_req    = r_ks_req;
  assign ks_count  = r_cnt;
  assign out_data  = r_out_data;
  assign out_en    = r_out_en;
  assign out_last  = r_out_last;
  assign mic_data  = r_mic_data;
  assign mic_en    = r_mic_en;
  assign err_short = r_err_short;

endmodule

// File: tb/tb_ccm_ctr_rx_unpack.sv
// Random and directed frames against a byte-level CCM CTR receive model.
module tb_ccm_ctr_rx_unpack;
  localparam int ML = 8;
  localparam int WC = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      input_data;
  logic            input_en, input_last;
  logic            out_ready, ks_req;
  logic [WC-1:0]   ks_count;
  logic [127:0]    ks_data;
  logic            ks_en;
  logic [7:0]      out_data;
  logic            out_en, out_last;
  logic [ML*8-1:0] mic_data;
  logic            mic_en, err_short;

  always #5 clk = ~clk;

  ccm_ctr_rx_unpack #(.WIDTH(8), .WIDTH_BLOCK(128), .WIDTH_COUNT(WC), .MIC_LEN(ML)) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .input_en(input_en),
    .input_last(input_last), .out_ready(out_ready), .ks_req(ks_req), .ks_count(ks_count),
    .ks_data(ks_data), .ks_en(ks_en), .out_data(out_data), .out_en(out_en),
    .out_last(out_last), .mic_data(mic_data), .mic_en(mic_en), .err_short(err_short)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] ks_mem [16];
  logic [7:0]   frm [64];
  bit           ks_gate = 1'b0;
  int           ks_fixed = 0;
  int           ks_wait = 0;
  int           exp_ks = 0;
  int           ks_hs_n = 0;

  logic [7:0]      got_q [$];
  bit              last_q [$];
  logic [ML*8-1:0] mic_got;
  int              mic_n = 0;
  int              short_n = 0;

  function automatic logic [7:0] ksb(input int b, input int j);
    logic [127:0] w;
    w = ks_mem[b];
    return w[127-8*j -: 8];
  endfunction

  // Keystream engine: answers ks_req after a configurable delay while the gate is open.
  initial begin
    ks_en = 1'b0;
    ks_data = '0;
    forever begin
      @(posedge clk); #1;
      ks_en = 1'b0;
      if (reset && ks_req && ks_gate) begin
        if (ks_wait > 0) ks_wait--;
        else begin
          ks_data = ks_mem[ks_count[3:0]];
          ks_en = 1'b1;
          chk("ks_count", 128'(ks_count), 128'(exp_ks));
          exp_ks++;
          ks_hs_n++;
          ks_wait = (ks_fixed >= 0) ? ks_fixed : $urandom_range(0, 3);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_en) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (mic_en) begin
        mic_n++;
        mic_got = mic_data;
      end
      if (err_short) short_n++;
    end
  end

  task automatic finish_now(input string why);
    $display("FAIL %s: bound expired", why);
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bound expired");
  endtask

  task automatic open_gate();
    exp_ks = 0;
    ks_hs_n = 0;
    ks_wait = (ks_fixed >= 0) ? ks_fixed : $urandom_range(0, 3);
    ks_gate = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been taken.
  task automatic send_byte(input int i, input int n, input bit junk);
    int t;
    t = 0;
    while (!out_ready) begin
      if (t > 500) finish_now("wait_ready");
      input_en   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      input_data = 8'($urandom);
      input_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    input_en   = 1'b1;
    input_data = frm[i];
    input_last = (i == n - 1);
    @(posedge clk); #1;
    input_en   = 1'b0;
    input_last = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit junk, input bit stall_chk);
    int t, np;
    bit short_f;
    logic [ML*8-1:0] em;
    got_q.delete();
    last_q.delete();
    mic_n = 0;
    short_n = 0;
    open_gate();
    for (int i = 0; i < n; i++) begin
      if (stall_chk && i > 0 && (i % 16) == 0) begin
        chk("stall_ready", 128'(out_ready), 128'(0));
        chk("stall_req", 128'(ks_req), 128'(1));
        chk("stall_count", 128'(ks_count), 128'(i / 16 + 1));
      end
      send_byte(i, n, junk);
    end
    t = 0;
    while (!(mic_en || err_short)) begin
      @(negedge clk);
      t++;
      if (t > 500) finish_now("wait_done");
    end
    ks_gate = 1'b0;
    @(posedge clk); #1;
    short_f = (n < ML);
    np = short_f ? 0 : n - ML;
    chk("n_out", 128'(got_q.size()), 128'(np));
    for (int i = 0; i < np && i < got_q.size(); i++) begin
      chk("out_data", 128'(got_q[i]), 128'(frm[i] ^ ksb(1 + i / 16, i % 16)));
      chk("out_last", 128'(last_q[i]), 128'(i == np - 1));
    end
    chk("mic_n", 128'(mic_n), 128'(short_f ? 0 : 1));
    chk("short_n", 128'(short_n), 128'(short_f ? 1 : 0));
    if (!short_f) begin
      em = '0;
      for (int k = 0; k < ML; k++) em = {em[ML*8-9:0], frm[n-ML+k] ^ ksb(0, k)};
      chk("mic_data", 128'(mic_got), 128'(em));
    end
    chk("ks_blocks", 128'(ks_hs_n), 128'((n - 1) / 16 + 2));
  endtask

  task automatic set_t1();
    ks_mem[0] = {16{8'hFF}};
    ks_mem[1] = 128'h000102030405060708090A0B0C0D0E0F;
    ks_mem[2] = {16{8'h55}};
    for (int i = 0; i < 64; i++) frm[i] = 8'(8'h10 + i);
  endtask

  logic [7:0] save_q [$];
  int         sz0, n;

  initial begin
    reset = 1'b0;
    input_en = 1'b0;
    input_last = 1'b0;
    input_data = '0;
    for (int b = 0; b < 16; b++) ks_mem[b] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ks_req", 128'(ks_req), 128'(0));
    chk("rst_ks_count", 128'(ks_count), 128'(0));
    chk("rst_ready", 128'(out_ready), 128'(0));
    chk("rst_out_en", 128'(out_en), 128'(0));
    chk("rst_mic_en", 128'(mic_en), 128'(0));
    chk("rst_short", 128'(err_short), 128'(0));
    chk("rst_mic_data", 128'(mic_data), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // 12-byte frame: four 0x10 payload bytes, MIC = raw tail ^ 0xFF
    set_t1();
    ks_fixed = 0;
    run_frame(12, 1'b0, 1'b0);
    chk("t1_out0", 128'(got_q[0]), 128'(8'h10));
    chk("t1_out3", 128'(got_q[3]), 128'(8'h10));
    chk("t1_mic", 128'(mic_got), 128'(64'hEBEAE9E8E7E6E5E4));

    // 24-byte frame with a slow keystream engine across the block boundary
    ks_fixed = 7;
    run_frame(24, 1'b0, 1'b1);
    save_q = got_q;

    // same frame with illegal input_en pulses while out_ready is low
    ks_fixed = 2;
    run_frame(24, 1'b1, 1'b0);
    chk("junk_n", 128'(got_q.size()), 128'(save_q.size()));
    for (int i = 0; i < save_q.size() && i < got_q.size(); i++)
      chk("junk_data", 128'(got_q[i]), 128'(save_q[i]));

    // length == MIC_LEN: no payload, MIC only
    ks_fixed = 0;
    for (int k = 0; k < 16; k++) ks_mem[0][127-8*k -: 8] = 8'h11;
    for (int i = 0; i < 8; i++) frm[i] = 8'(i);
    run_frame(8, 1'b0, 1'b0);
    chk("t3_mic", 128'(mic_got), 128'(64'h1110131215141716));

    // short frames, then back in REQ0 with count 0
    run_frame(5, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_req", 128'(ks_req), 128'(1));
    chk("idle_count", 128'(ks_count), 128'(0));

    // reset in the middle of a 20-byte frame
    set_t1();
    open_gate();
    for (int i = 0; i < 10; i++) send_byte(i, 20, 1'b0);
    sz0 = got_q.size();
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 128'(ks_req), 128'(0));
    chk("mid_rst_ready", 128'(out_ready), 128'(0));
    chk("mid_rst_out_en", 128'(out_en), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    ks_gate = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_out", 128'(got_q.size()), 128'(sz0));
    run_frame(12, 1'b0, 1'b0);
    chk("rst_t1_mic", 128'(mic_got), 128'(64'hEBEAE9E8E7E6E5E4));

    // block-boundary lengths and random frames
    for (int r = 0; r < 16; r++) begin
      case (r)
        0: n = 16;
        1: n = 32;
        2: n = 9;
        3: n = 17;
        default: n = $urandom_range(1, 40);
      endcase
      for (int b = 0; b < 4; b++) ks_mem[b] = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
      ks_fixed = (r < 4) ? 0 : -1;
      run_frame(n, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccm_ctr_rx_unpack.md
Name: ccm_ctr_rx_unpack

Overview:
- Receive-side counterpart of the CCM CTR encrypt path.
- Accepts a ciphertext byte stream whose last MIC_LEN bytes are the encrypted MIC. Fetches keystream blocks S0, S1, S2, … from an external AES keystream engine.
- Emits decrypted payload bytes (ciphertext XOR Si, i≥1) and the decrypted MIC (tail XOR S0), which is handed to the downstream CBC-MAC compare.
- Sits between the link receiver and the MIC check block.

Parameters:
- WIDTH, 8, data byte width.
- WIDTH_BLOCK, 128, keystream block width (16 bytes).
- WIDTH_COUNT, 20, CTR counter field width.
- MIC_LEN, 8, MIC length in bytes (legal: 4, 6, 8, 10, 12, 14, 16).

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- input_data  input  WIDTH  ciphertext byte.
- input_en  input  1  byte valid; legal only while out_ready=1.
- input_last  input  1  marks final byte of frame; qualified by input_en.
- out_ready  output  1  block can accept a byte this cycle.
- ks_req  output  1  keystream request, level, held until ks_en.
- ks_count  output  WIDTH_COUNT  counter index requested; stable while ks_req=1.
- ks_data  input  WIDTH_BLOCK  keystream block; byte 0 = [127:120].
- ks_en  input  1  ks_data valid; ignored unless ks_req=1.
- out_data  output  WIDTH  plaintext payload byte.
- out_en  output  1  out_data valid.
- out_last  output  1  final payload byte; coincident with out_en.
- mic_data  output  MIC_LEN*8  decrypted MIC; first MIC byte in MSBs.
- mic_en  output  1  one-cycle pulse, mic_data valid.
- err_short  output  1  one-cycle pulse, frame shorter than MIC_LEN bytes.

Behaviour:
- Reset (async, active-low): all outputs 0, state REQ0, counter 0, delay line empty, S0/Si registers 0. Reset mid-frame discards the frame. ks_req drops immediately. No out_en/mic_en is produced for the discarded frame.
- FSM states: REQ0, REQ1, RUN, REQN, DONE.
  - REQ0: ks_req=1, ks_count=0. On ks_en, store S0 → REQ1.
  - REQ1: ks_req=1, ks_count=1. On ks_en, load Si, byte index=0 → RUN.
  - RUN: out_ready=1. Each accepted byte advances the byte index.
    - Accepting index 15 without input_last: counter+1 → REQN.
    - input_last accepted (any index) → DONE.
  - REQN: out_ready=0, ks_req=1, ks_count=counter. On ks_en, load Si, index=0 → RUN.
  - DONE: single cycle; emits the frame end, clears counter and delay line → REQ0.
- out_ready=0 in every state except RUN. input_en while out_ready=0 is ignored: no state change, byte dropped.
- Decrypt path, per accepted byte:
  - Compute d = input_data XOR Si[byte index].
  - Push the pair {raw byte, d} into a MIC_LEN-deep holdback line.
  - If the line was already full, the oldest d is emitted.
- Output timing: out_en and out_data are registered, one cycle after the accepting cycle.
- Frame end, on the input_last accept:
  - If a byte is emitted on that accept, its out_en cycle also carries out_last=1.
  - In that same cycle (the DONE cycle), mic_data = held raw bytes XOR S0 bytes 0..MIC_LEN-1, and mic_en=1.
- Length boundaries:
  - Length == MIC_LEN: no out_en at all; mic_en only.
  - Length < MIC_LEN: err_short=1 in the DONE cycle; no mic_en, no out_en.
  - Length 1: same as above.
- Counter: increments modulo 2^WIDTH_COUNT. Frames longer than (2^WIDTH_COUNT−1)·16 bytes are out of scope.
- Keystream latency: ks_en may arrive any number of cycles after ks_req, including the next cycle. The block stalls with out_ready=0 and holds no data loss.
- input_last on byte index 15 goes directly to DONE; no refill request is issued.

Test Plan:
- MIC_LEN=8, S0=16×0xFF, S1=0x00,0x01,…,0x0F; 12-byte frame 0x10..0x1B → out_data 0x10,0x10,0x10,0x10 with out_last on the 4th; mic_en with mic_data=0xEBEAE9E8E7E6E5E4 in the same cycle.
- 24-byte frame, S1 as above, S2=16×0x55 → after byte 16, out_ready=0 and ks_req with ks_count=2 until ks_en (delayed 7 cycles); bytes 17–24 XOR 0x55; 16 payload bytes out, out_last on the 16th.
- 8-byte frame 0x00..0x07, S0=0x11 repeated → zero out_en; mic_en with mic_data=0x1110131215141716.
- 5-byte frame → err_short pulse, no out_en/mic_en; FSM returns to REQ0 with ks_count=0.
- Assert reset low mid-frame at byte 10 of 20 → ks_req, out_en, out_ready=0 immediately; after release, a clean 12-byte frame decodes as in test 1.
- input_en pulsed during REQN and REQ1 → byte ignored; output byte count and values unchanged versus the same frame without the illegal pulses.
